// File: rtl/ddr_tx_pkg.sv
// Shared types and helpers for the DDR transmit serializer.
package ddr_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } state_t;

    // Width of the lead-in / trail guard cycle counter.
    localparam int GUARD_CNT_W = 4;

    // Beat counter width: enough to index WORD_W/2 beats, never less than one bit.
    function automatic int beat_cnt_w(input int word_w);
        int w;
        w = $clog2(word_w / 2);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ddr_tx_shift_reg.sv
// Word holding register feeding the ODDR pair. A pop presents the top two
// bits of the word (or of the word being loaded in the same cycle) as d1/d2
// and keeps the remainder; with no pop the outputs fall back to the idle level.
module ddr_tx_shift_reg
    import ddr_tx_pkg::*;
#(
    parameter int   WORD_W     = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              pop,
    input  logic [WORD_W-1:0] data,
    output logic              d1,
    output logic              d2
);

    logic [WORD_W-1:0] rest_reg;
    logic [WORD_W-1:0] source;

    // A load and pop in the same cycle sends beat 0 straight from the new word.
    always_comb begin
        source = load ? data : rest_reg;
    end

    // Remaining bits plus registered beat outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rest_reg <= '0;
            d1       <= IDLE_LEVEL;
            d2       <= IDLE_LEVEL;
        end else if (pop) begin
            rest_reg <= source << 2;
            d1       <= source[WORD_W-1];
            d2       <= source[WORD_W-2];
        end else begin
            if (load) begin
                rest_reg <= data;
            end
            d1 <= IDLE_LEVEL;
            d2 <= IDLE_LEVEL;
        end
    end

endmodule

// File: rtl/ddr_tx_serializer.sv
// Splits parallel words into per-clock DDR bit pairs and frames each burst
// with a programmable output-enable lead-in and trail.
module ddr_tx_serializer
    import ddr_tx_pkg::*;
#(
    parameter int   WORD_W     = 8,
    parameter int   LEAD_CYC   = 1,
    parameter int   TRAIL_CYC  = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              oddr_d1,
    output logic              oddr_d2,
    output logic              oddr_oe,
    output logic              busy,
    output logic              word_done
);

    localparam int BEAT_W = beat_cnt_w(WORD_W);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORD_W / 2 - 1);
    localparam logic [GUARD_CNT_W-1:0] LEAD_INIT  = GUARD_CNT_W'((LEAD_CYC > 0) ? LEAD_CYC - 1 : 0);
    localparam logic [GUARD_CNT_W-1:0] TRAIL_INIT = GUARD_CNT_W'((TRAIL_CYC > 0) ? TRAIL_CYC - 1 : 0);

    state_t                 state_reg, state_next;
    logic [BEAT_W-1:0]      beat_reg, beat_next;
    logic [GUARD_CNT_W-1:0] guard_reg, guard_next;
    logic                   oe_reg, done_reg;
    logic                   run_reg;
    logic                   load, pop, accept;

    // Ready depends only on state, beat position and enable; run_reg keeps it
    // low until the first clock after reset release.
    always_comb begin
        s_ready = 1'b0;
        case (state_reg)
            IDLE:    s_ready = enable;
            LEAD:    s_ready = 1'b0;
            SHIFT:   s_ready = enable && (beat_reg == LAST_BEAT);
            TRAIL:   s_ready = enable;
            default: s_ready = 1'b0;
        endcase
        s_ready = s_ready && run_reg;
    end

    assign accept = s_valid && s_ready;

    // Next-state, counters and shift-register control.
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        guard_next = guard_reg;
        load       = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    if (LEAD_CYC == 0) begin
                        pop        = 1'b1;
                        state_next = SHIFT;
                        beat_next  = '0;
                    end else begin
                        state_next = LEAD;
                        guard_next = LEAD_INIT;
                    end
                end
            end
            LEAD: begin
                // The held word goes out regardless of enable.
                if (guard_reg == '0) begin
                    pop        = 1'b1;
                    state_next = SHIFT;
                    beat_next  = '0;
                end else begin
                    guard_next = guard_reg - GUARD_CNT_W'(1);
                end
            end
            SHIFT: begin
                if (beat_reg == LAST_BEAT) begin
                    beat_next = '0;
                    if (accept) begin
                        load = 1'b1;
                        pop  = 1'b1;
                    end else if (TRAIL_CYC == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = TRAIL;
                        guard_next = TRAIL_INIT;
                    end
                end else begin
                    pop       = 1'b1;
                    beat_next = beat_reg + BEAT_W'(1);
                end
            end
            TRAIL: begin
                // oe is still high, so a new word skips the lead-in.
                if (accept) begin
                    load       = 1'b1;
                    pop        = 1'b1;
                    state_next = SHIFT;
                    beat_next  = '0;
                end else if (guard_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    guard_next = guard_reg - GUARD_CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters and registered oe / word_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            guard_reg <= '0;
            oe_reg    <= 1'b0;
            done_reg  <= 1'b0;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            guard_reg <= guard_next;
            oe_reg    <= (state_next != IDLE);
            done_reg  <= pop && (beat_next == LAST_BEAT);
            run_reg   <= 1'b1;
        end
    end

    ddr_tx_shift_reg #(
        .WORD_W     (WORD_W),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_shift (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .pop  (pop),
        .data (s_data),
        .d1   (oddr_d1),
        .d2   (oddr_d2)
    );

    assign oddr_oe   = oe_reg;
    assign word_done = done_reg;
    assign busy      = (state_reg != IDLE);

endmodule
